// File: rtl/spinner_pkg.sv
// -----------------------------------------------------------------------------
// spinner_pkg
// Shared types and helpers for the multi-channel spinner/paddle emulator.
//   MODE_WRAP / MODE_CLAMP : position arithmetic mode selectors
//   dir_e                  : 2-bit last-direction encoding per channel
//   sat_add()              : position + signed delta, clamped in MODE_CLAMP;
//                            in MODE_WRAP the caller truncates to WIDTH bits,
//                            which gives the modulo-2^WIDTH behaviour
// -----------------------------------------------------------------------------
package spinner_pkg;

  localparam logic MODE_WRAP  = 1'b0;
  localparam logic MODE_CLAMP = 1'b1;

  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_INC  = 2'b01,
    DIR_DEC  = 2'b10
  } dir_e;

  // Signed add done wider than WIDTH+1 so neither overflow nor a negative
  // intermediate is lost before clamping / truncation.
  function automatic int sat_add(input int   pos_v,
                                 input int   delta_v,
                                 input int   min_v,
                                 input int   max_v,
                                 input logic mode_v);
    int sum_v;
    sum_v = pos_v + delta_v;
    if (mode_v == MODE_CLAMP) begin
      if (sum_v < min_v) begin
        sum_v = min_v;
      end else if (sum_v > max_v) begin
        sum_v = max_v;
      end else begin
        sum_v = sum_v;
      end
    end else begin
      sum_v = sum_v;
    end
    return sum_v;
  endfunction

endpackage

// File: rtl/spinner_multi_if.sv
// -----------------------------------------------------------------------------
// spinner_multi_if
// Bundle between the input/host side and the spinner block.
//   tick        : frame strobe (VSync level); rising edge triggers an update
//   btn_inc/dec : per-channel buttons, active-high
//   load_*      : one-cycle host request to set a channel position
//   pos         : packed positions, channel c at [c*WIDTH +: WIDTH]
//   moved       : one-cycle pulse when a channel position changed
//   dir         : direction of last move per channel (1 = increment)
// master drives the requests and reads positions; slave is the spinner.
// -----------------------------------------------------------------------------
interface spinner_multi_if #(
  parameter int NUM_CH = 2,
  parameter int WIDTH  = 8
);
  logic                      tick;
  logic [NUM_CH-1:0]         btn_inc;
  logic [NUM_CH-1:0]         btn_dec;
  logic                      load_valid;
  logic [1:0]                load_ch;
  logic [WIDTH-1:0]          load_value;
  logic [NUM_CH*WIDTH-1:0]   pos;
  logic [NUM_CH-1:0]         moved;
  logic [NUM_CH-1:0]         dir;

  modport master (
    output tick, btn_inc, btn_dec, load_valid, load_ch, load_value,
    input  pos, moved, dir
  );

  modport slave (
    input  tick, btn_inc, btn_dec, load_valid, load_ch, load_value,
    output pos, moved, dir
  );
endinterface

// File: rtl/spinner_channel.sv
// -----------------------------------------------------------------------------
// spinner_channel
// One channel: position, acceleration step, hold counter, last direction and
// the registered moved/dir outputs.
//   clk, rst_n     : clock, asynchronous active-low reset
//   upd_i          : single-cycle update strobe (tick rising edge)
//   inc_i / dec_i  : buttons, sampled only when upd_i is high
//   load_i         : load request for this channel (wins over upd_i)
//   load_value_i   : value to load (clamped in clamp mode)
//   pos_o          : current position
//   moved_o        : one-cycle pulse, position changed on this update
//   dir_o          : direction of the last real move (1 = increment)
// -----------------------------------------------------------------------------
module spinner_channel
  import spinner_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int MODE        = 0,
  parameter int POS_MIN     = 0,
  parameter int POS_MAX     = 255,
  parameter int POS_RESET   = 128,
  parameter int STEP_MIN    = 1,
  parameter int STEP_MAX    = 8,
  parameter int ACCEL_TICKS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             upd_i,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic [WIDTH-1:0] pos_o,
  output logic             moved_o,
  output logic             dir_o
);

  localparam int   SW       = $clog2(STEP_MAX + 1) + 1;
  localparam int   HW       = $clog2(ACCEL_TICKS + 1) + 1;
  localparam logic MODE_SEL = (MODE == 1) ? MODE_CLAMP : MODE_WRAP;

  logic [WIDTH-1:0] pos_q,   pos_d;
  logic [SW-1:0]    step_q,  step_d;
  logic [HW-1:0]    hold_q,  hold_d;
  dir_e             last_q,  last_d;
  logic             moved_q, moved_d;
  logic             dir_q,   dir_d;
  dir_e             cur_dir_s;
  int               delta_s;
  int               sum_s;

  // Next-state: load first, then per-tick move/acceleration rules.
  always_comb begin
    pos_d     = pos_q;
    step_d    = step_q;
    hold_d    = hold_q;
    last_d    = last_q;
    moved_d   = 1'b0;
    dir_d     = dir_q;
    cur_dir_s = DIR_NONE;
    delta_s   = 0;
    sum_s     = 0;
    if (load_i) begin
      sum_s  = sat_add(int'(load_value_i), 0, POS_MIN, POS_MAX, MODE_SEL);
      pos_d  = WIDTH'(sum_s);
      step_d = SW'(STEP_MIN);
      hold_d = HW'(0);
      last_d = DIR_NONE;
    end else if (upd_i) begin
      if (inc_i == dec_i) begin
        // Both or neither: acceleration state collapses back to idle.
        step_d = SW'(STEP_MIN);
        hold_d = HW'(0);
        last_d = DIR_NONE;
      end else begin
        cur_dir_s = inc_i ? DIR_INC : DIR_DEC;
        if (cur_dir_s != last_q) begin
          delta_s = STEP_MIN;
          step_d  = SW'(STEP_MIN);
          hold_d  = HW'(1);
        end else begin
          delta_s = int'(step_q);
          // >= rather than == keeps ACCEL_TICKS=1 accelerating after the
          // first tick, where hold already starts at 1.
          if (int'(hold_q) + 1 >= ACCEL_TICKS) begin
            hold_d = HW'(0);
            if (int'(step_q) < STEP_MAX) begin
              step_d = step_q + SW'(1);
            end else begin
              step_d = SW'(STEP_MAX);
            end
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        last_d = cur_dir_s;
        sum_s  = sat_add(int'(pos_q), inc_i ? delta_s : -delta_s,
                         POS_MIN, POS_MAX, MODE_SEL);
        // Truncation to WIDTH is the wrap in MODE_WRAP; a no-op when clamped.
        pos_d  = WIDTH'(sum_s);
        if (pos_d != pos_q) begin
          moved_d = 1'b1;
          dir_d   = inc_i;
        end else begin
          moved_d = 1'b0;
          dir_d   = dir_q;
        end
      end
    end else begin
      moved_d = 1'b0;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q   <= WIDTH'(POS_RESET);
      step_q  <= SW'(STEP_MIN);
      hold_q  <= HW'(0);
      last_q  <= DIR_NONE;
      moved_q <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      step_q  <= step_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      moved_q <= moved_d;
      dir_q   <= dir_d;
    end
  end

  assign pos_o   = pos_q;
  assign moved_o = moved_q;
  assign dir_o   = dir_q;

endmodule

// File: rtl/spinner_multi.sv
// -----------------------------------------------------------------------------
// spinner_multi
// Multi-channel digital spinner/paddle emulator. Turns per-channel inc/dec
// buttons into WIDTH-bit absolute positions, updated on each frame tick
// rising edge, with hold-time acceleration and wrap or clamp arithmetic.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : spinner_multi_if slave (tick, buttons, load path, outputs)
// Holds the tick edge detector and the load demux; channels do the rest.
// -----------------------------------------------------------------------------
module spinner_multi
  import spinner_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int WIDTH       = 8,
  parameter int MODE        = 0,
  parameter int POS_MIN     = 0,
  parameter int POS_MAX     = 255,
  parameter int POS_RESET   = 128,
  parameter int STEP_MIN    = 1,
  parameter int STEP_MAX    = 8,
  parameter int ACCEL_TICKS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  spinner_multi_if.slave  bus
);

  logic                    tick_q,  tick_d;
  logic                    armed_q, armed_d;
  logic                    upd_s;
  logic [NUM_CH*WIDTH-1:0] pos_s;
  logic [NUM_CH-1:0]       moved_s;
  logic [NUM_CH-1:0]       dir_s;

  // Edge detector next state. tick_q alone resets to 0, so a tick held high
  // across reset release would look like a rising edge; armed only sets
  // once tick has been seen low, forcing a fresh edge after reset.
  always_comb begin
    tick_d  = bus.tick;
    armed_d = armed_q | ~bus.tick;
  end

  // Edge detector registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      armed_q <= armed_d;
    end
  end

  assign upd_s = bus.tick & ~tick_q & armed_q;

  // Load requests for channels that do not exist simply match no channel.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic load_sel_s;
    assign load_sel_s = bus.load_valid & (int'(bus.load_ch) == c);

    spinner_channel #(
      .WIDTH       (WIDTH),
      .MODE        (MODE),
      .POS_MIN     (POS_MIN),
      .POS_MAX     (POS_MAX),
      .POS_RESET   (POS_RESET),
      .STEP_MIN    (STEP_MIN),
      .STEP_MAX    (STEP_MAX),
      .ACCEL_TICKS (ACCEL_TICKS)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .upd_i        (upd_s),
      .inc_i        (bus.btn_inc[c]),
      .dec_i        (bus.btn_dec[c]),
      .load_i       (load_sel_s),
      .load_value_i (bus.load_value),
      .pos_o        (pos_s[c*WIDTH +: WIDTH]),
      .moved_o      (moved_s[c]),
      .dir_o        (dir_s[c])
    );
  end

  assign bus.pos   = pos_s;
  assign bus.moved = moved_s;
  assign bus.dir   = dir_s;

endmodule

// File: tb/tb_spinner_multi.sv
// -----------------------------------------------------------------------------
// tb_spinner_multi
// Directed bench for spinner_multi: one wrap-mode instance (defaults) and one
// clamp-mode instance (POS_MIN=16, POS_MAX=240), sharing clock and reset.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_spinner_multi;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  spinner_multi_if #(.NUM_CH(2), .WIDTH(8)) if_w ();
  spinner_multi_if #(.NUM_CH(2), .WIDTH(8)) if_c ();

  spinner_multi #(.NUM_CH(2), .WIDTH(8), .MODE(0)) dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_w)
  );

  spinner_multi #(.NUM_CH(2), .WIDTH(8), .MODE(1), .POS_MIN(16), .POS_MAX(240)) dut_c (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_c)
  );

  task automatic drive_idle();
    if_w.tick = 1'b0; if_w.btn_inc = 2'b00; if_w.btn_dec = 2'b00;
    if_w.load_valid = 1'b0; if_w.load_ch = 2'd0; if_w.load_value = 8'd0;
    if_c.tick = 1'b0; if_c.btn_inc = 2'b00; if_c.btn_dec = 2'b00;
    if_c.load_valid = 1'b0; if_c.load_ch = 2'd0; if_c.load_value = 8'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Low for one cycle, then high: the update is visible at return.
  task automatic pulse_tick();
    if_w.tick = 1'b0; if_c.tick = 1'b0;
    @(negedge clk);
    if_w.tick = 1'b1; if_c.tick = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_w(input logic [1:0] ch, input logic [7:0] v);
    if_w.load_valid = 1'b1; if_w.load_ch = ch; if_w.load_value = v;
    @(negedge clk);
    if_w.load_valid = 1'b0;
  endtask

  task automatic load_c(input logic [1:0] ch, input logic [7:0] v);
    if_c.load_valid = 1'b1; if_c.load_ch = ch; if_c.load_value = v;
    @(negedge clk);
    if_c.load_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    if_w.tick = 1'b1; if_w.btn_inc = 2'b11;
    if_c.tick = 1'b1; if_c.btn_inc = 2'b11;
    @(negedge clk);
    @(negedge clk);
    compared++;
    if (if_w.pos !== 16'h8080 || if_w.moved !== 2'b00 || if_w.dir !== 2'b00) begin
      mismatched++;
      $display("FAIL reset_w: pos=%h moved=%b dir=%b want pos=8080 moved=00 dir=00", if_w.pos, if_w.moved, if_w.dir);
    end
    compared++;
    if (if_c.pos !== 16'h8080 || if_c.moved !== 2'b00) begin
      mismatched++;
      $display("FAIL reset_c: pos=%h moved=%b want pos=8080 moved=00", if_c.pos, if_c.moved);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++;
      if (if_w.pos !== 16'h8080 || if_w.moved !== 2'b00 || if_c.pos !== 16'h8080) begin
        mismatched++;
        $display("FAIL tick_high_release[%0d]: pos_w=%h moved_w=%b pos_c=%h want 8080/00/8080", i, if_w.pos, if_w.moved, if_c.pos);
      end
    end
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      pulse_tick();
      compared++;
      if (if_w.pos !== 16'h8080 || if_w.moved !== 2'b00) begin
        mismatched++;
        $display("FAIL idle_tick[%0d]: pos=%h moved=%b want 8080/00", i, if_w.pos, if_w.moved);
      end
    end
  endtask

  task automatic test_accel();
    int         steps [10] = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3};
    logic [7:0] exp_pos;
    do_reset();
    exp_pos = 8'd128;
    if_w.btn_inc = 2'b01;
    for (int i = 0; i < 10; i++) begin
      pulse_tick();
      exp_pos = exp_pos + 8'(steps[i]);
      compared++;
      if (if_w.pos[7:0] !== exp_pos || if_w.moved !== 2'b01 || if_w.dir[0] !== 1'b1 || if_w.pos[15:8] !== 8'd128) begin
        mismatched++;
        $display("FAIL accel[%0d]: pos0=%0d moved=%b dir0=%b pos1=%0d want %0d/01/1/128",
                 i, if_w.pos[7:0], if_w.moved, if_w.dir[0], if_w.pos[15:8], exp_pos);
      end
    end
    @(negedge clk);
    compared++;
    if (if_w.pos[7:0] !== 8'd146 || if_w.moved !== 2'b00) begin
      mismatched++;
      $display("FAIL accel_end: pos0=%0d moved=%b want 146/00", if_w.pos[7:0], if_w.moved);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] inc_exp [3] = '{8'd255, 8'd0, 8'd1};
    logic [7:0] dec_exp [2] = '{8'd0, 8'd255};
    do_reset();
    load_w(2'd0, 8'd254);
    compared++;
    if (if_w.pos[7:0] !== 8'd254 || if_w.moved[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL wrap_load: pos0=%0d moved0=%b want 254/0", if_w.pos[7:0], if_w.moved[0]);
    end
    if_w.btn_inc = 2'b01;
    for (int i = 0; i < 3; i++) begin
      pulse_tick();
      compared++;
      if (if_w.pos[7:0] !== inc_exp[i] || if_w.moved[0] !== 1'b1 || if_w.dir[0] !== 1'b1) begin
        mismatched++;
        $display("FAIL wrap_inc[%0d]: pos0=%0d moved0=%b dir0=%b want %0d/1/1", i, if_w.pos[7:0], if_w.moved[0], if_w.dir[0], inc_exp[i]);
      end
    end
    if_w.btn_inc = 2'b00;
    if_w.btn_dec = 2'b01;
    for (int i = 0; i < 2; i++) begin
      pulse_tick();
      compared++;
      if (if_w.pos[7:0] !== dec_exp[i] || if_w.moved[0] !== 1'b1 || if_w.dir[0] !== 1'b0) begin
        mismatched++;
        $display("FAIL wrap_dec[%0d]: pos0=%0d moved0=%b dir0=%b want %0d/1/0", i, if_w.pos[7:0], if_w.moved[0], if_w.dir[0], dec_exp[i]);
      end
    end
  endtask

  task automatic test_clamp();
    do_reset();
    load_c(2'd0, 8'd250);
    compared++;
    if (if_c.pos[7:0] !== 8'd240 || if_c.moved[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL clamp_load: pos0=%0d moved0=%b want 240/0", if_c.pos[7:0], if_c.moved[0]);
    end
    if_c.btn_inc = 2'b01;
    pulse_tick();
    compared++;
    if (if_c.pos[7:0] !== 8'd240 || if_c.moved[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL clamp_at_max: pos0=%0d moved0=%b want 240/0", if_c.pos[7:0], if_c.moved[0]);
    end
    if_c.btn_inc = 2'b00;
    if_c.btn_dec = 2'b01;
    pulse_tick();
    compared++;
    if (if_c.pos[7:0] !== 8'd239 || if_c.moved[0] !== 1'b1 || if_c.dir[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL clamp_dec: pos0=%0d moved0=%b dir0=%b want 239/1/0", if_c.pos[7:0], if_c.moved[0], if_c.dir[0]);
    end
  endtask

  task automatic test_both_buttons();
    do_reset();
    load_w(2'd1, 8'd100);
    if_w.btn_inc = 2'b10;
    for (int i = 0; i < 8; i++) begin
      pulse_tick();
    end
    compared++;
    if (if_w.pos[15:8] !== 8'd112) begin
      mismatched++;
      $display("FAIL both_prep: pos1=%0d want 112", if_w.pos[15:8]);
    end
    if_w.btn_dec = 2'b10;
    pulse_tick();
    compared++;
    if (if_w.pos[15:8] !== 8'd112 || if_w.moved[1] !== 1'b0) begin
      mismatched++;
      $display("FAIL both_pressed: pos1=%0d moved1=%b want 112/0", if_w.pos[15:8], if_w.moved[1]);
    end
    if_w.btn_dec = 2'b00;
    pulse_tick();
    compared++;
    if (if_w.pos[15:8] !== 8'd113 || if_w.moved[1] !== 1'b1) begin
      mismatched++;
      $display("FAIL both_release: pos1=%0d moved1=%b want 113/1", if_w.pos[15:8], if_w.moved[1]);
    end
  endtask

  task automatic test_load_priority();
    do_reset();
    if_w.btn_inc = 2'b11;
    if_w.tick = 1'b1;
    if_w.load_valid = 1'b1; if_w.load_ch = 2'd1; if_w.load_value = 8'd50;
    @(negedge clk);
    if_w.load_valid = 1'b0;
    compared++;
    if (if_w.pos !== 16'h3281 || if_w.moved !== 2'b01) begin
      mismatched++;
      $display("FAIL load_prio: pos=%h moved=%b want 3281/01", if_w.pos, if_w.moved);
    end
    if_w.tick = 1'b0;
    if_w.btn_inc = 2'b00;
    load_w(2'd3, 8'd7);
    @(negedge clk);
    compared++;
    if (if_w.pos !== 16'h3281 || if_w.moved !== 2'b00) begin
      mismatched++;
      $display("FAIL load_bad_ch: pos=%h moved=%b want 3281/00", if_w.pos, if_w.moved);
    end
  endtask

  initial begin
    test_reset();
    test_accel();
    test_wrap();
    test_clamp();
    test_both_buttons();
    test_load_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
